// File: rtl/exp_pair_scheduler_pkg.sv
// Shared widths, state enum and helpers for the exponent-pair scheduler.
// Operand magnitudes are 8 bits, so bit indices are 3 bits and their sum is 4.
package exp_pair_scheduler_pkg;

  localparam int OPERAND_W = 8;
  localparam int EXP_W     = 3;
  localparam int SUM_W     = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [SUM_W-1:0] sum_exps(
    input logic [EXP_W-1:0] a,
    input logic [EXP_W-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/exp_pair_scheduler_lsb.sv
// Lowest-set-bit finder: index of the least significant 1 in vec.
// When vec is zero, found is low and idx reads as 0.
module lowest_set_bit
  import exp_pair_scheduler_pkg::*;
(
  input  logic [OPERAND_W-1:0] vec,
  output logic [EXP_W-1:0]     idx,
  output logic                 found
);

  // Scan from the top so that the lowest set bit is the one left in idx.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = OPERAND_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = EXP_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_pair_scheduler.sv
// Walks every (activation bit, weight bit) pair of one operand pair and
// emits the summed bit exponents, activation-bit-major, one beat per cycle.
module exp_pair_scheduler
  import exp_pair_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [OPERAND_W-1:0] InAct,
  input  logic [OPERAND_W-1:0] InWeight,
  input  logic                 InSign,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [SUM_W-1:0]     SumExps,
  output logic                 OutSign,
  output logic                 OutZero,
  output logic                 OutLast
);

  state_e                 state_q, state_d;
  logic [OPERAND_W-1:0]   w_q, w_d;
  logic [OPERAND_W-1:0]   arem_q, arem_d;
  logic [OPERAND_W-1:0]   wrem_q, wrem_d;
  logic                   sign_q, sign_d;
  logic                   zero_q, zero_d;

  logic [EXP_W-1:0]       a_idx, w_idx;
  logic                   a_any, w_any;
  logic                   a_one, w_one;
  logic                   run;
  logic [OPERAND_W-1:0]   wrem_clr;

  lowest_set_bit u_lsb_a (
    .vec   (arem_q),
    .idx   (a_idx),
    .found (a_any)
  );

  lowest_set_bit u_lsb_w (
    .vec   (wrem_q),
    .idx   (w_idx),
    .found (w_any)
  );

  assign run      = (state_q == RUN);
  assign a_one    = a_any &&
                    ((arem_q & (arem_q - OPERAND_W'(1))) == '0);
  assign w_one    = w_any &&
                    ((wrem_q & (wrem_q - OPERAND_W'(1))) == '0);
  assign wrem_clr = wrem_q & (wrem_q - OPERAND_W'(1));

  // Outputs are combinational so SumExps reaches the one-hot stage directly.
  assign InReady  = !run;
  assign OutValid = run;
  assign OutSign  = sign_q;
  assign OutZero  = run && zero_q;
  assign OutLast  = run && (zero_q || (a_one && w_one));
  assign SumExps  = (run && !zero_q) ? sum_exps(a_idx, w_idx) : '0;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    arem_d  = arem_q;
    wrem_d  = wrem_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          w_d     = InWeight;
          arem_d  = InAct;
          wrem_d  = InWeight;
          sign_d  = InSign;
          zero_d  = (InAct == '0) || (InWeight == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        if (OutReady) begin
          if (OutLast) state_d = IDLE;
          if (!zero_q) begin
            wrem_d = wrem_clr;
            // Weight bits exhausted: step to the next activation bit.
            if (wrem_clr == '0) begin
              arem_d = arem_q & (arem_q - OPERAND_W'(1));
              wrem_d = w_q;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      arem_q  <= '0;
      wrem_q  <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      arem_q  <= arem_d;
      wrem_q  <= wrem_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_exp_pair_scheduler.sv
// Self-checking bench for exp_pair_scheduler: directed table, corner
// sequences and randomized pairs against a bit-pair enumeration model.
module tb_exp_pair_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       InValid;
  logic       InReady;
  logic [7:0] InAct;
  logic [7:0] InWeight;
  logic       InSign;
  logic       OutValid;
  logic       OutReady;
  logic [3:0] SumExps;
  logic       OutSign;
  logic       OutZero;
  logic       OutLast;

  int n_cmp = 0;
  int n_err = 0;

  exp_pair_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InAct    (InAct),
    .InWeight (InWeight),
    .InSign   (InSign),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .SumExps  (SumExps),
    .OutSign  (OutSign),
    .OutZero  (OutZero),
    .OutLast  (OutLast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] w;
    logic       s;
    int         beats;
    int         first;
    int         last;
    int         maxv;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!InReady && guard < 200) begin
      tick();
      guard++;
    end
    check("in_ready_wait", {31'd0, InReady}, 32'd1);
  endtask

  // Offer one pair, drain all beats, check each against the model.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] w,
                           input logic s, input int stall,
                           input bit keep_valid,
                           output int beats, output int first,
                           output int last, output int maxv);
    logic [3:0] q[$];
    logic       z;
    logic [6:0] prev, cur, expb;
    bit         held, done;
    int         guard;
    z = (a == 8'd0) || (w == 8'd0);
    if (z) q.push_back(4'd0);
    else
      for (int i = 0; i < 8; i++)
        if (a[i])
          for (int j = 0; j < 8; j++)
            if (w[j]) q.push_back(4'(i + j));
    beats = 0; first = -1; last = -1; maxv = 0;
    prev = '0; held = 0; done = 0; guard = 0;
    wait_ready();
    InValid = 1'b1; InAct = a; InWeight = w; InSign = s;
    OutReady = 1'b0;
    tick();
    InValid = keep_valid;
    while (!done && guard < 2000) begin
      if (keep_valid) begin
        InAct = 8'($urandom); InWeight = 8'($urandom);
        InSign = 1'($urandom);
      end
      cur = {SumExps, OutSign, OutZero, OutLast};
      check("out_valid", {31'd0, OutValid}, 32'd1);
      expb = (q.size() > 0) ? {q[0], s, z, q.size() == 1} : 7'h7f;
      check("beat", {25'd0, cur}, {25'd0, expb});
      if (held) check("stall_hold", {25'd0, cur}, {25'd0, prev});
      prev = cur;
      OutReady = ($urandom_range(99) >= stall);
      held = OutValid && !OutReady;
      if (OutValid && OutReady) begin
        beats++;
        if (beats == 1) first = int'(SumExps);
        last = int'(SumExps);
        if (int'(SumExps) > maxv) maxv = int'(SumExps);
        if (q.size() > 0) void'(q.pop_front());
        done = OutLast;
      end
      tick();
      guard++;
    end
    InValid = 1'b0; OutReady = 1'b0;
    check("pair_done", {31'd0, done}, 32'd1);
    check("model_drained", q.size(), 32'd0);
    check("bubble_ready", {31'd0, InReady}, 32'd1);
    check("bubble_valid", {31'd0, OutValid}, 32'd0);
  endtask

  initial begin
    int b, f, l, m;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 4,  0,  3,  3};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 64, 0,  14, 14};
    tbl[2] = '{8'h00, 8'h7F, 1'b1, 1,  0,  0,  0};
    tbl[3] = '{8'h81, 8'h10, 1'b0, 2,  4,  11, 11};
    tbl[4] = '{8'h02, 8'h02, 1'b1, 1,  2,  2,  2};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1,  14, 14, 14};
    tbl[6] = '{8'h01, 8'h01, 1'b0, 1,  0,  0,  0};
    tbl[7] = '{8'h00, 8'h00, 1'b0, 1,  0,  0,  0};

    rst = 1'b1; InValid = 1'b0; InAct = '0; InWeight = '0;
    InSign = 1'b0; OutReady = 1'b0;
    repeat (3) tick();
    // Reset must win over an offered pair.
    InValid = 1'b1; InAct = 8'h33; InWeight = 8'h11; OutReady = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, InReady}, 32'd1);
    check("rst_out_valid", {31'd0, OutValid}, 32'd0);
    check("rst_sum", {28'd0, SumExps}, 32'd0);
    check("rst_sign", {31'd0, OutSign}, 32'd0);
    check("rst_zero", {31'd0, OutZero}, 32'd0);
    check("rst_last", {31'd0, OutLast}, 32'd0);
    rst = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      send_pair(tbl[k].a, tbl[k].w, tbl[k].s, 0, 1'b0, b, f, l, m);
      check($sformatf("tbl%0d_beats", k), b, tbl[k].beats);
      check($sformatf("tbl%0d_first", k), f, tbl[k].first);
      check($sformatf("tbl%0d_last", k), l, tbl[k].last);
      check($sformatf("tbl%0d_max", k), m, tbl[k].maxv);
    end

    // Backpressure on the first beat of 0x81/0x10.
    wait_ready();
    InValid = 1'b1; InAct = 8'h81; InWeight = 8'h10; InSign = 1'b0;
    tick();
    InValid = 1'b0; OutReady = 1'b0;
    check("bp_first", {25'd0, SumExps, OutValid, OutLast},
          {25'd0, 4'd4, 1'b1, 1'b0});
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold", {25'd0, SumExps, OutValid, OutLast},
            {25'd0, 4'd4, 1'b1, 1'b0});
    end
    OutReady = 1'b1;
    tick();
    check("bp_second", {25'd0, SumExps, OutValid, OutLast},
          {25'd0, 4'd11, 1'b1, 1'b1});
    tick();
    OutReady = 1'b0;
    check("bp_ready_back", {31'd0, InReady}, 32'd1);

    // Reset during the second beat of 0x0F/0x0F.
    InValid = 1'b1; InAct = 8'h0F; InWeight = 8'h0F;
    tick();
    InValid = 1'b0; OutReady = 1'b1;
    check("mid_beat1", {28'd0, SumExps}, 32'd0);
    tick();
    check("mid_beat2", {27'd0, OutValid, SumExps}, {27'd1, 4'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0; OutReady = 1'b0;
    check("mid_rst", {29'd0, OutValid, InReady, OutLast}, 32'b010);
    send_pair(8'h02, 8'h02, 1'b0, 0, 1'b0, b, f, l, m);
    check("post_rst_beats", b, 1);
    check("post_rst_sum", l, 2);

    // Operands churn with InValid high during RUN; must be ignored.
    send_pair(8'h05, 8'h03, 1'b1, 25, 1'b1, b, f, l, m);
    check("churn_beats", b, 4);
    check("churn_last", l, 3);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rw;
      ra = 8'($urandom);
      rw = 8'($urandom);
      if ($urandom_range(7) == 0) ra = 8'd0;
      if ($urandom_range(7) == 0) rw = 8'd0;
      send_pair(ra, rw, 1'($urandom), 30, 1'($urandom), b, f, l, m);
      check("rand_beats", b,
            (ra == 0 || rw == 0) ? 1 : $countones(ra) * $countones(rw));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exp_pair_scheduler.md
EXP_PAIR_SCHEDULER -- requirements
Module: exp_pair_scheduler

Interface
REQ-001 Parameters: none; all widths SHALL come from the shared package (OPERAND_W=8, EXP_W=3, SUM_W=4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 InValid  input  1  operand pair offered.
REQ-005 InReady  output  1  block can accept an operand pair.
REQ-006 InAct  input  8  activation magnitude.
REQ-007 InWeight  input  8  weight magnitude.
REQ-008 InSign  input  1  product sign (activation sign XOR weight sign).
REQ-009 OutValid  output  1  exponent-sum beat present.
REQ-010 OutReady  input  1  downstream one-hot/accumulate stage accepts the beat.
REQ-011 SumExps  output  4  exponent of activation bit plus exponent of weight bit, range 0..14.
REQ-012 OutSign  output  1  latched InSign of the current pair.
REQ-013 OutZero  output  1  beat carries no contribution (either operand zero).
REQ-014 OutLast  output  1  final beat of the current operand pair.

Function
REQ-015 States SHALL be IDLE and RUN; the input handshake SHALL occur when InValid && InReady.
REQ-016 InReady SHALL be 1 only in IDLE; OutValid SHALL be 1 only in RUN.
REQ-017 On accept: latch W=InWeight, ARem=InAct, WRem=InWeight, sign=InSign, zero=(InAct==0 || InWeight==0); go to RUN; first OutValid SHALL appear the following cycle (latency 1).
REQ-018 In RUN with zero=0: SumExps SHALL equal the lowest-set-bit index of ARem plus the lowest-set-bit index of WRem, 3+3 -> 4 bits, unsigned, no overflow.
REQ-019 On output handshake with zero=0: clear the lowest set bit of WRem; if WRem becomes 0, clear the lowest set bit of ARem and reload WRem=W.
REQ-020 OutLast SHALL be 1 when ARem and WRem each have exactly one set bit, or when zero=1.
REQ-021 Beats per pair SHALL equal popcount(InAct)*popcount(InWeight), emitted activation-bit-major and weight-bit-minor, ascending bit order.
REQ-022 With zero=1: exactly one beat with OutZero=1, SumExps=0, OutLast=1.
REQ-023 Handshake on an OutLast beat SHALL return to IDLE; InReady SHALL rise the next cycle (one bubble per pair).
REQ-024 While OutValid && !OutReady, SumExps, OutSign, OutZero and OutLast SHALL hold stable and internal state SHALL not advance.
REQ-025 InValid in RUN SHALL be ignored; upstream holds the operands until InReady.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, OutValid=0, InReady=1, SumExps=0, OutSign=0, OutZero=0, OutLast=0, and clear ARem, WRem, W; it SHALL take priority over any handshake in that cycle.
REQ-027 Reset mid-pair SHALL drop the remaining beats, with no partial OutLast.

Structure
REQ-028 The shared package SHALL hold OPERAND_W, EXP_W, SUM_W and the state enum {IDLE, RUN}.
REQ-029 A sub-module lowest_set_bit (8-bit in, 3-bit index out, plus a single-bit flag) SHALL be instantiated twice, once for ARem and once for WRem.
REQ-030 SumExps SHALL feed the downstream one-hot conversion directly, with no added register.

Verification
REQ-031 InAct=0x05, InWeight=0x03, OutReady=1 -> beats SumExps 0,1,2,3, with OutLast on the 4th; InReady returns the cycle after.
REQ-032 InAct=0xFF, InWeight=0xFF -> 64 beats; the first is 0, the last is 14 with OutLast=1; no value exceeds 14.
REQ-033 InAct=0x00, InWeight=0x7F, InSign=1 -> a single beat with OutZero=1, SumExps=0, OutLast=1, OutSign=1.
REQ-034 InAct=0x81, InWeight=0x10, OutReady held low 3 cycles after the first beat -> SumExps=4 held stable, then 11 with OutLast=1.
REQ-035 Assert rst in the 2nd beat of InAct=0x0F, InWeight=0x0F -> the next cycle shows OutValid=0 and InReady=1; a new pair 0x02/0x02 then yields one beat with SumExps=2 and OutLast=1.
REQ-036 Hold InValid high with changing operands during RUN -> operands are not sampled until IDLE.
